// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding decode
// through a small instruction buffer (FIFO_DEPTH entries, 2 or 4).
// Optional feature: define FETCH_BYPASS_EN to forward a returning response
// straight to decode when the buffer is empty (1-cycle fetch-to-decode).
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]  DEPTH_C = 3'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [2:0]         count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        buf_instr_q [FIFO_DEPTH];
  logic [31:0]        buf_instr_d [FIFO_DEPTH];
  logic [31:0]        buf_pc_q    [FIFO_DEPTH];
  logic [31:0]        buf_pc_d    [FIFO_DEPTH];

  logic               fifo_empty;
  logic               grant;
  logic               resp_kept;
  logic               bypass_hit;
  logic               push;
  logic               pop;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;

  // Request side: only IDLE may issue, and only if the buffer has room.
  always_comb begin
    fifo_empty  = (count_q == '0);
    imem_req_o  = !rst_i && !redirect_i && (state_q == S_IDLE) && (count_q < DEPTH_C);
    imem_addr_o = fetch_pc_q;
    grant       = imem_req_o && imem_gnt_i;
    resp_kept   = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i && !rst_i;
  end

  // Decode side: buffer head, or the live response when bypass is enabled.
  always_comb begin
`ifdef FETCH_BYPASS_EN
    bypass_hit = resp_kept && fifo_empty;
`else
    bypass_hit = 1'b0;
`endif
    out_instr = buf_instr_q[rd_ptr_q];
    out_pc    = buf_pc_q[rd_ptr_q];
    if (bypass_hit) begin
      out_instr = imem_rdata_i;
      out_pc    = resp_pc_q;
    end
    id_valid_o    = !rst_i && !redirect_i && (!fifo_empty || bypass_hit);
    id_instr_o    = id_valid_o ? out_instr : NOP;
    id_pc_o       = rst_i ? '0 : out_pc;
    id_pc_plus4_o = id_pc_o + 32'd4;
    pop           = id_valid_o && id_ready_i && !fifo_empty;
    push          = resp_kept && !(bypass_hit && id_ready_i);
  end

  // Next-state: FSM, fetch PC, buffer pointers/contents, redirect flush.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      resp_pc_d  = fetch_pc_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving alongside the redirect is already consumed,
        // so DROP is only needed when it is still in flight.
        if (redirect_i) state_d = imem_rvalid_i ? S_IDLE : S_DROP;
        else if (imem_rvalid_i) state_d = S_IDLE;
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      buf_instr_d[wr_ptr_q] = imem_rdata_i;
      buf_pc_d[wr_ptr_q]    = resp_pc_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + 3'(push) - 3'(pop);

    if (redirect_i) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc_i & ~32'h3;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC & ~32'h3;
      resp_pc_q   <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      buf_instr_q <= '{default: '0};
      buf_pc_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: transaction-queue reference model plus
// directed scenario tasks and a randomized run.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_pc_plus4_o(id_pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Sampled DUT outputs for the cycle just stepped.
  logic        s_req, s_valid, s_grant;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  // Reference model: queue of PCs fetched (kept) but not yet handed to decode.
  logic [31:0] mq[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  bit          m_kept_out = 1'b0;

  // Model expectations for the cycle just stepped.
  logic        e_req, e_valid;
  logic [31:0] e_addr, e_pc, e_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  // One clock cycle: inputs are already set; sample, predict, advance model,
  // then present the memory response for the next cycle.
  task automatic tick();
    int   arrived;
    logic m_xfer, m_grant, rv_next;
    logic [31:0] rd_next;
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = id_valid_o;
    s_instr = id_instr_o;
    s_pc    = id_pc_o;
    s_pc4   = id_pc_plus4_o;
    s_grant = s_req && imem_gnt_i;

    arrived = mq.size() - (m_kept_out ? 1 : 0);
    e_req   = !rst_i && !redirect_i && !m_kept_out && (mq.size() < DEPTH);
    e_addr  = m_fetch_pc;
    e_valid = !rst_i && !redirect_i && (arrived > 0 || (BYP && m_kept_out));
    e_pc    = e_valid ? mq[0] : 32'h0;
    e_instr = e_valid ? memf(mq[0]) : NOP;
    m_xfer  = e_valid && id_ready_i;
    m_grant = e_req && imem_gnt_i;
    rv_next = s_grant;
    rd_next = memf(s_addr);

    @(posedge clk);
    if (rst_i) begin
      mq.delete();
      m_fetch_pc = RESET_PC;
      m_kept_out = 1'b0;
    end else if (redirect_i) begin
      mq.delete();
      m_fetch_pc = redirect_pc_i & ~32'h3;
      m_kept_out = 1'b0;
    end else begin
      if (m_xfer) void'(mq.pop_front());
      m_kept_out = 1'b0;
      if (m_grant) begin
        mq.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_kept_out = 1'b1;
      end
    end
    @(negedge clk);
    imem_rvalid_i = rv_next;
    imem_rdata_i  = rv_next ? rd_next : $urandom;
  endtask

  task automatic test_reset();
    int g0, v0, n;
    logic [31:0] next_a;
    rst_i = 1'b1; imem_gnt_i = 1'b1; id_ready_i = 1'b1; redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", s_req); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", s_valid); end
      checks++; if (s_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", s_instr, NOP); end
      checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", s_pc); end
    end
    rst_i = 1'b0;
    g0 = -1; v0 = -1; next_a = RESET_PC;
    for (n = 0; n < 12; n++) begin
      tick();
      if (n == 0) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
          errors++; $display("FAIL first_req: got req=%b addr=%h want 1 %h", s_req, s_addr, RESET_PC);
        end
      end
      if (s_grant) begin
        checks++;
        if (s_addr !== next_a) begin errors++; $display("FAIL addr_seq: got %h want %h", s_addr, next_a); end
        next_a = next_a + 32'd4;
        if (g0 < 0) g0 = n;
      end
      if (s_valid && v0 < 0) begin
        v0 = n;
        checks++; if (s_pc !== RESET_PC) begin errors++; $display("FAIL first_pc: got %h want %h", s_pc, RESET_PC); end
      end
    end
    checks++;
    if (g0 < 0 || v0 - g0 != LAT) begin
      errors++; $display("FAIL latency: got %0d want %0d", v0 - g0, LAT);
    end
  endtask

  task automatic test_stall();
    logic        held;
    logic [31:0] h_instr, h_pc;
    imem_gnt_i = 1'b1; id_ready_i = 1'b0; held = 1'b0; h_instr = '0; h_pc = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL stall_req: got %b want %b", s_req, e_req); end
      if (s_valid && held) begin
        checks++;
        if (s_instr !== h_instr || s_pc !== h_pc) begin
          errors++; $display("FAIL stall_hold: got %h@%h want %h@%h", s_instr, s_pc, h_instr, h_pc);
        end
      end
      if (s_valid && !held) begin held = 1'b1; h_instr = s_instr; h_pc = s_pc; end
    end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b want 0", s_req); end
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_full_valid: got %b want 1", s_valid); end
    id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (s_valid !== e_valid) begin errors++; $display("FAIL drain_valid: got %b want %b", s_valid, e_valid); end
      if (e_valid) begin
        checks++; if (s_pc !== e_pc) begin errors++; $display("FAIL drain_pc: got %h want %h", s_pc, e_pc); end
      end
    end
  endtask

  task automatic test_gnt_low();
    logic [31:0] a;
    int k;
    id_ready_i = 1'b1; imem_gnt_i = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!s_req && k < 8);
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL gl_req_seen: got %b want 1", s_req); end
    a = s_addr;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_req !== 1'b1 || s_addr !== a) begin
        errors++; $display("FAIL gl_hold: got req=%b addr=%h want 1 %h", s_req, s_addr, a);
      end
    end
    imem_gnt_i = 1'b1;
    tick();
    checks++; if (s_addr !== a) begin errors++; $display("FAIL gl_grant_addr: got %h want %h", s_addr, a); end
    k = 0;
    do begin tick(); k++; end while (!s_req && k < 6);
    checks++; if (s_addr !== a + 32'd4) begin errors++; $display("FAIL gl_next_addr: got %h want %h", s_addr, a + 32'd4); end
  endtask

  task automatic test_redirect();
    int k;
    id_ready_i = 1'b1; imem_gnt_i = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!s_grant && k < 8);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_valid: got %b want 0", s_valid); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_req: got %b want 0", s_req); end
    redirect_i = 1'b0;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200) begin
      errors++; $display("FAIL rd_next_addr: got req=%b addr=%h want 1 00000200", s_req, s_addr);
    end
    k = 0;
    while (!s_valid && k < 6) begin tick(); k++; end
    checks++; if (s_pc !== 32'h200 || !s_valid) begin errors++; $display("FAIL rd_next_pc: got %h want 00000200", s_pc); end
    checks++; if (s_instr !== memf(32'h200)) begin errors++; $display("FAIL rd_next_instr: got %h want %h", s_instr, memf(32'h200)); end
  endtask

  task automatic test_wrap();
    bit saw_top, addr_ok, pc4_ok;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8; id_ready_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    saw_top = 1'b0; addr_ok = 1'b0; pc4_ok = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_grant && saw_top && !addr_ok) begin
        addr_ok = 1'b1;
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", s_addr); end
      end
      if (s_grant && s_addr == 32'hFFFF_FFFC) saw_top = 1'b1;
      if (s_valid && s_pc == 32'hFFFF_FFFC && !pc4_ok) begin
        pc4_ok = 1'b1;
        checks++; if (s_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 00000000", s_pc4); end
      end
    end
    checks++; if (!(addr_ok && pc4_ok)) begin errors++; $display("FAIL wrap_seen: got addr=%b pc4=%b want 1 1", addr_ok, pc4_ok); end
  endtask

  task automatic test_reset_in_wait();
    int k, g;
    id_ready_i = 1'b1; imem_gnt_i = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!s_grant && k < 8);
    rst_i = 1'b1;
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rw_rst_valid: got %b want 0", s_valid); end
    rst_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rw_spurious_valid: got %b want 0", s_valid); end
    checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      errors++; $display("FAIL rw_req: got req=%b addr=%h want 1 %h", s_req, s_addr, RESET_PC);
    end
    g = 0;
    while (!s_valid && g < 6) begin tick(); g++; end
    checks++; if (g != LAT) begin errors++; $display("FAIL rw_latency: got %0d want %0d", g, LAT); end
    checks++; if (s_pc !== RESET_PC) begin errors++; $display("FAIL rw_pc: got %h want %h", s_pc, RESET_PC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      imem_gnt_i = ($urandom_range(0, 9) < 7);
      id_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i = ($urandom_range(0, 29) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick();
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL rnd_req: got %b want %b", s_req, e_req); end
      if (e_req) begin
        checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rnd_addr: got %h want %h", s_addr, e_addr); end
      end
      checks++; if (s_valid !== e_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b", s_valid, e_valid); end
      checks++; if (s_instr !== e_instr) begin errors++; $display("FAIL rnd_instr: got %h want %h", s_instr, e_instr); end
      if (e_valid) begin
        checks++; if (s_pc !== e_pc) begin errors++; $display("FAIL rnd_pc: got %h want %h", s_pc, e_pc); end
        checks++; if (s_pc4 !== e_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4: got %h want %h", s_pc4, e_pc + 32'd4); end
      end
    end
    redirect_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
    test_reset();
    test_stall();
    test_gnt_low();
    test_redirect();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
